// File: rtl/wireout_mailbox_arbiter_pkg.sv
// Shared definitions for the FrontPanel wire-out mailbox arbiter.
// Covers the FSM encoding, the mailbox and status word field layout, and the pointer helper.
package wireout_mailbox_arbiter_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  localparam int SRC_W          = 3;
  localparam int WORD_W         = 16;

  // mbox_word = {seq, src[2:0], payload[11:0]}
  localparam int MBOX_PAYLOAD_LSB = 0;
  localparam int MBOX_PAYLOAD_W   = 12;
  localparam int MBOX_SRC_LSB     = 12;
  localparam int MBOX_SEQ_BIT     = 15;

  // status_word = {drop_cnt[7:0], busy, seq, 3'b000, last_src[2:0]}
  localparam int STAT_SRC_LSB   = 0;
  localparam int STAT_SEQ_BIT   = 6;
  localparam int STAT_BUSY_BIT  = 7;
  localparam int STAT_DROP_LSB  = 8;
  localparam int DROP_W         = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;
  localparam int CNT_MIN_W = 24;

  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + SRC_W'(1);
  endfunction

endpackage

// File: rtl/wireout_mailbox_arbiter_rr_pick.sv
// Round-robin priority picker: first asserted request at or after ptr, wrapping at N.
// Purely combinational; grant is one-hot or zero, idx is valid only when any is set.
module rr_pick
  import wireout_mailbox_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = SRC_W
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wireout_mailbox_arbiter.sv
// Arbitrates N_REQ message sources onto a single 16-bit wire-out mailbox word.
// The host acknowledges by mirroring seq on ack_tog; unacknowledged messages time out and count as drops.
module wireout_mailbox_arbiter
  import wireout_mailbox_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PAYLOAD_W = 12,
  parameter int TIMEOUT   = 1000000
) (
  input  logic                       ti_clk,
  input  logic                       ti_rst_n,
  input  logic                       enable,
  input  logic                       ack_tog,
  input  logic                       clear_drops,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*PAYLOAD_W-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [WORD_W-1:0]          mbox_word,
  output logic [WORD_W-1:0]          status_word
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > CNT_MIN_W) ? $clog2(TIMEOUT + 1) : CNT_MIN_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              r_state;
  logic                r_seq;
  logic [WORD_W-1:0]   r_mbox;
  logic [DROP_W-1:0]   r_drop;
  logic [SRC_W-1:0]    r_last_src;
  logic [SRC_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_cnt;

  logic [N_REQ-1:0]    w_grant;
  logic [SRC_W-1:0]    w_idx;
  logic                w_any;
  logic                w_open;
  logic                w_xfer;
  logic                w_ack;
  logic                w_tmo;
  logic                w_busy;
  logic                w_drop_inc;
  logic [PAYLOAD_W-1:0] w_payload;

  rr_pick #(.N(N_REQ), .IW(SRC_W)) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Ready is forced low while reset is held, even though the state already reads IDLE.
  assign w_open     = ti_rst_n && (r_state == ST_IDLE) && enable && w_any;
  assign req_ready  = w_open ? w_grant : '0;
  assign w_xfer     = |(req_valid & req_ready);
  assign w_payload  = req_data[int'(w_idx)*PAYLOAD_W +: PAYLOAD_W];

  assign w_busy     = (r_state == ST_WAIT_ACK);
  assign w_ack      = (ack_tog == r_seq);
  assign w_tmo      = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_drop_inc = w_busy && !w_ack && w_tmo;

  always_ff @(posedge ti_clk or negedge ti_rst_n) begin
    if (!ti_rst_n) begin
      r_state    <= ST_IDLE;
      r_seq      <= 1'b0;
      r_mbox     <= '0;
      r_last_src <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_xfer) begin
            r_mbox     <= {~r_seq, w_idx, w_payload};
            r_seq      <= ~r_seq;
            r_last_src <= w_idx;
            r_ptr      <= next_ptr(w_idx, N_REQ);
            r_state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // Ack has priority over a coincident timeout, so that cycle never counts as a drop.
          if (w_ack || w_tmo) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ti_clk or negedge ti_rst_n) begin
    if (!ti_rst_n) begin
      r_drop <= '0;
    end else if (clear_drops) begin
      r_drop <= '0;
    end else if (w_drop_inc && (r_drop != DROP_MAX)) begin
      r_drop <= r_drop + DROP_W'(1);
    end
  end

  assign mbox_word   = r_mbox;
  assign status_word = {r_drop, w_busy, r_seq, 3'b000, r_last_src};

endmodule

// File: tb/tb_wireout_mailbox_arbiter.sv
// Self-checking bench for wireout_mailbox_arbiter with a transaction-level reference model.
// TIMEOUT is shortened to 16 cycles so drop behaviour is reachable.
module tb_wireout_mailbox_arbiter;

  localparam int N  = 4;
  localparam int PW = 12;
  localparam int TO = 16;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic            ack_tog;
  logic            clear_drops;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [15:0]     mbox_word;
  logic [15:0]     status_word;

  int total;
  int bad;

  // reference model state
  logic        m_busy;
  logic        m_seq;
  logic [15:0] m_mbox;
  logic [2:0]  m_last;
  int          m_drop;
  int          m_wait;
  int          m_ptr;

  wireout_mailbox_arbiter #(.N_REQ(N), .PAYLOAD_W(PW), .TIMEOUT(TO)) dut (
    .ti_clk      (clk),
    .ti_rst_n    (rst_n),
    .enable      (enable),
    .ack_tog     (ack_tog),
    .clear_drops (clear_drops),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .mbox_word   (mbox_word),
    .status_word (status_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int m_winner();
    if (m_busy || !enable) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int w;
    logic [N-1:0] v;
    w = m_winner();
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] m_status();
    return {8'(m_drop), m_busy, m_seq, 3'b000, m_last};
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_seq = 1'b0; m_mbox = '0; m_last = '0;
    m_drop = 0; m_wait = 0; m_ptr = 0;
  endtask

  task automatic model_clock();
    int w;
    logic inc;
    w   = m_winner();
    inc = 1'b0;
    if (!m_busy) begin
      if (w >= 0) begin
        m_seq  = ~m_seq;
        m_mbox = {m_seq, 3'(w), req_data[w*PW +: PW]};
        m_last = 3'(w);
        m_ptr  = (w + 1) % N;
        m_busy = 1'b1;
        m_wait = 0;
      end
    end else if (ack_tog == m_seq) begin
      m_busy = 1'b0;
    end else if (m_wait == TO - 1) begin
      m_busy = 1'b0;
      inc    = 1'b1;
    end else begin
      m_wait++;
    end
    if (clear_drops) m_drop = 0;
    else if (inc && m_drop < 255) m_drop++;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; ack_tog = 1'b0; clear_drops = 1'b0;
    req_valid = 4'hF; req_data = 48'({$urandom, $urandom});
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%h exp=%h", req_ready, 4'h0); end
    total++; if (mbox_word !== 16'h0) begin bad++; $display("FAIL reset_mbox got=%h exp=%h", mbox_word, 16'h0); end
    total++; if (status_word !== 16'h0) begin bad++; $display("FAIL reset_status got=%h exp=%h", status_word, 16'h0); end
    model_reset();
    req_valid = '0;
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL post_reset_ready got=%h exp=%h", req_ready, 4'h0); end
  endtask

  task automatic test_single();
    enable = 1'b1; req_valid = 4'b0100; req_data[2*PW +: PW] = 12'hABC;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%h exp=%h", req_ready, 4'b0100); end
    tick();
    req_valid = '0;
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL single_ready_wait got=%h exp=%h", req_ready, 4'h0); end
    total++; if (mbox_word !== 16'hAABC) begin bad++; $display("FAIL single_mbox got=%h exp=%h", mbox_word, 16'hAABC); end
    total++; if (status_word !== 16'h00C2) begin bad++; $display("FAIL single_status got=%h exp=%h", status_word, 16'h00C2); end
    ack_tog = 1'b1;
    tick();
    total++; if (status_word[7] !== 1'b0) begin bad++; $display("FAIL single_ack_busy got=%b exp=%b", status_word[7], 1'b0); end
    total++; if (mbox_word !== 16'hAABC) begin bad++; $display("FAIL single_hold got=%h exp=%h", mbox_word, 16'hAABC); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_rdy;
    rst_n = 1'b0;
    #1;
    model_reset();
    ack_tog = 1'b0;
    rst_n = 1'b1;
    enable = 1'b1; req_valid = 4'hF; req_data = 48'({$urandom, $urandom});
    for (int g = 0; g < 6; g++) begin
      exp_rdy = '0;
      exp_rdy[g % N] = 1'b1;
      #1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL fair_grant%0d got=%h exp=%h", g, req_ready, exp_rdy); end
      tick();
      total++; if (mbox_word[14:12] !== 3'(g % N)) begin bad++; $display("FAIL fair_src%0d got=%0d exp=%0d", g, mbox_word[14:12], g % N); end
      total++; if (mbox_word[11:0] !== req_data[(g % N)*PW +: PW]) begin bad++; $display("FAIL fair_data%0d got=%h exp=%h", g, mbox_word[11:0], req_data[(g % N)*PW +: PW]); end
      ack_tog = m_seq;
      tick();
      total++; if (status_word[7] !== 1'b0) begin bad++; $display("FAIL fair_idle%0d got=%b exp=%b", g, status_word[7], 1'b0); end
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    logic [15:0] held;
    ack_tog = m_seq; req_valid = 4'b0010; req_data = 48'({$urandom, $urandom});
    #1;
    tick();
    req_valid = '0;
    held = {~ack_tog, 3'd1, req_data[PW +: PW]};
    total++; if (mbox_word !== held) begin bad++; $display("FAIL tmo_mbox got=%h exp=%h", mbox_word, held); end
    for (int i = 0; i < TO; i++) begin
      total++; if (status_word[7] !== 1'b1) begin bad++; $display("FAIL tmo_busy%0d got=%b exp=%b", i, status_word[7], 1'b1); end
      tick();
    end
    total++; if (status_word[7] !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%b exp=%b", status_word[7], 1'b0); end
    total++; if (status_word[15:8] !== 8'd1) begin bad++; $display("FAIL tmo_drop got=%0d exp=%0d", status_word[15:8], 1); end
    total++; if (mbox_word !== held) begin bad++; $display("FAIL tmo_hold got=%h exp=%h", mbox_word, held); end
  endtask

  task automatic test_ack_vs_timeout();
    ack_tog = m_seq; req_valid = 4'b1000;
    #1;
    tick();
    req_valid = '0;
    repeat (TO - 1) tick();
    total++; if (status_word[7] !== 1'b1) begin bad++; $display("FAIL race_busy got=%b exp=%b", status_word[7], 1'b1); end
    ack_tog = m_seq;
    tick();
    total++; if (status_word[7] !== 1'b0) begin bad++; $display("FAIL race_idle got=%b exp=%b", status_word[7], 1'b0); end
    total++; if (status_word[15:8] !== 8'd1) begin bad++; $display("FAIL race_drop got=%0d exp=%0d", status_word[15:8], 1); end
    for (int k = 0; k < 4; k++) begin
      ack_tog = m_seq; req_valid = 4'(1 << k);
      #1;
      tick();
      req_valid = '0;
      repeat (TO) tick();
      total++; if (status_word[15:8] !== 8'(2 + k)) begin bad++; $display("FAIL drop_count%0d got=%0d exp=%0d", k, status_word[15:8], 2 + k); end
    end
    ack_tog = m_seq; req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    repeat (TO - 1) tick();
    clear_drops = 1'b1;
    tick();
    clear_drops = 1'b0;
    total++; if (status_word[15:8] !== 8'd0) begin bad++; $display("FAIL clear_race got=%0d exp=%0d", status_word[15:8], 0); end
    total++; if (status_word[7] !== 1'b0) begin bad++; $display("FAIL clear_idle got=%b exp=%b", status_word[7], 1'b0); end
  endtask

  task automatic test_enable();
    logic [N-1:0] exp_rdy;
    enable = 1'b0; req_valid = 4'hF; ack_tog = m_seq;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL en_off_ready%0d got=%h exp=%h", i, req_ready, 4'h0); end
      tick();
      total++; if (status_word[7] !== 1'b0) begin bad++; $display("FAIL en_off_busy%0d got=%b exp=%b", i, status_word[7], 1'b0); end
    end
    enable = 1'b1;
    #1;
    exp_rdy = m_ready();
    total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL en_on_ready got=%h exp=%h", req_ready, exp_rdy); end
    tick();
    enable = 1'b0;
    tick();
    total++; if (status_word[7] !== 1'b1) begin bad++; $display("FAIL en_drop_busy got=%b exp=%b", status_word[7], 1'b1); end
    ack_tog = m_seq;
    tick();
    total++; if (status_word[7] !== 1'b0) begin bad++; $display("FAIL en_drop_ack got=%b exp=%b", status_word[7], 1'b0); end
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL en_nogrant%0d got=%h exp=%h", i, req_ready, 4'h0); end
      tick();
    end
    total++; if (status_word[7] !== 1'b0) begin bad++; $display("FAIL en_stay_idle got=%b exp=%b", status_word[7], 1'b0); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; req_valid = 4'hF; ack_tog = m_seq;
    #1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (mbox_word !== 16'h0) begin bad++; $display("FAIL rmid_mbox got=%h exp=%h", mbox_word, 16'h0); end
    total++; if (status_word !== 16'h0) begin bad++; $display("FAIL rmid_status got=%h exp=%h", status_word, 16'h0); end
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL rmid_ready got=%h exp=%h", req_ready, 4'h0); end
    model_reset();
    ack_tog = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_first got=%h exp=%h", req_ready, 4'b0001); end
    tick();
    total++; if (mbox_word[14:12] !== 3'd0) begin bad++; $display("FAIL rmid_src got=%0d exp=%0d", mbox_word[14:12], 0); end
    total++; if (status_word[15:8] !== 8'd0) begin bad++; $display("FAIL rmid_drop got=%0d exp=%0d", status_word[15:8], 0); end
    ack_tog = m_seq;
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_rdy;
    for (int c = 0; c < 400; c++) begin
      enable      = ($urandom_range(0, 9) != 0);
      req_valid   = 4'($urandom);
      req_data    = 48'({$urandom, $urandom});
      clear_drops = ($urandom_range(0, 63) == 0);
      if (m_busy) ack_tog = ($urandom_range(0, 11) == 0) ? m_seq : ~m_seq;
      else        ack_tog = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = m_ready();
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%h exp=%h", c, req_ready, exp_rdy); end
      tick();
      total++; if (mbox_word !== m_mbox) begin bad++; $display("FAIL rnd_mbox c=%0d got=%h exp=%h", c, mbox_word, m_mbox); end
      total++; if (status_word !== m_status()) begin bad++; $display("FAIL rnd_status c=%0d got=%h exp=%h", c, status_word, m_status()); end
    end
    clear_drops = 1'b0;
    req_valid   = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_ack_vs_timeout();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wireout_mailbox_arbiter.md
WIREOUT_MAILBOX_ARBITER -- requirements
Module: wireout_mailbox_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (legal 2..8).
REQ-002 SHALL have parameter PAYLOAD_W, default 12, payload bits per message (fixed 12; 16-bit mailbox word).
REQ-003 SHALL have parameter TIMEOUT, default 1000000, ti_clk cycles to wait for host ack (0 = never time out).
REQ-004 SHALL have port ti_clk  input  1  sole clock (FrontPanel host-interface clock).
REQ-005 SHALL have port ti_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  grant enable (wire-in bit).
REQ-007 SHALL have port ack_tog  input  1  host ack toggle (wire-in bit).
REQ-008 SHALL have port clear_drops  input  1  one-cycle pulse (trigger-in) zeroing drop counter.
REQ-009 SHALL have port req_valid  input  N_REQ  per-requester message valid.
REQ-010 SHALL have port req_data  input  N_REQ*12  per-requester payload, requester i at [i*12 +: 12].
REQ-011 SHALL have port req_ready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-012 SHALL have port mbox_word  output  16  to wire-out: {seq, src[2:0], payload[11:0]}.
REQ-013 SHALL have port status_word  output  16  to wire-out: {drop_cnt[7:0], busy, seq, 3'b000, last_src[2:0]}.

Function
REQ-014 SHALL implement FSM states IDLE and WAIT_ACK; busy = (state == WAIT_ACK).
REQ-015 In IDLE with enable=1 and any req_valid, req_ready SHALL assert combinationally for exactly the round-robin winner; otherwise req_ready = 0.
REQ-016 Transfer occurs when req_valid[i] & req_ready[i]; on the next edge SHALL load mbox_word = {~seq, i, req_data[i]}, invert seq, set last_src = i, enter WAIT_ACK (latency 1 cycle).
REQ-017 Round-robin: search starts at rr_ptr, ascending, wrapping at N_REQ; after a grant to i, rr_ptr = (i+1) mod N_REQ.
REQ-018 In WAIT_ACK, req_ready SHALL be 0; when ack_tog == seq, SHALL return to IDLE next edge; earliest next grant is the cycle after return.
REQ-019 In WAIT_ACK, a 24-bit-minimum cycle counter SHALL count from 0; at count == TIMEOUT-1 without ack, SHALL return to IDLE and increment drop_cnt (saturating at 255).
REQ-020 Ack and timeout in the same cycle: ack wins, no drop counted.
REQ-021 clear_drops SHALL zero drop_cnt next edge; clear and increment in the same cycle yield 0.
REQ-022 enable deasserted during WAIT_ACK SHALL NOT abort the transaction; it only blocks new grants.
REQ-023 mbox_word SHALL hold its value after ack or timeout until the next transfer.
REQ-024 Requester holding req_valid without grant SHALL NOT lose data; no internal buffering beyond mbox_word.

Reset
REQ-025 On ti_rst_n low (asynchronous): state=IDLE, seq=0, mbox_word=0, drop_cnt=0, last_src=0, rr_ptr=0, timeout counter=0; req_ready=0 while reset asserted.
REQ-026 Reset asserted mid-WAIT_ACK SHALL discard the pending message; no drop counted.

Structure
REQ-027 Shared package SHALL hold state encoding, MBOX field positions/widths, status field positions, DROP_MAX=255.
REQ-028 Round-robin priority picker SHALL be one sub-module rr_pick (inputs req vector, ptr; outputs one-hot grant, index, any).

Verification
REQ-029 Single request: enable=1, req_valid[2]=1, data 0xABC -> req_ready[2] one cycle, next cycle mbox_word=0xAABC, busy=1; ack_tog=1 -> IDLE next edge.
REQ-030 Fairness: all 4 requesters continuously valid, host acks each -> grant order 0,1,2,3,0,1; no requester granted twice before others.
REQ-031 Timeout: TIMEOUT=16, no ack -> busy for 16 cycles, then IDLE, drop_cnt=1, mbox_word unchanged.
REQ-032 Ack and timeout same cycle -> drop_cnt unchanged; clear_drops with drop_cnt=5 and simultaneous timeout -> drop_cnt=0.
REQ-033 enable=0 with valid requests -> req_ready stays 0; enable dropped during WAIT_ACK -> ack still completes, no further grant.
REQ-034 ti_rst_n asserted mid-WAIT_ACK -> all outputs zero immediately, drop_cnt=0, first post-reset grant goes to requester 0.
